mux_2to1_arbiter: RTL and testbench

- Shares one 8-bit mux_2to1 datapath between two requesters (in1, in2) using valid/ready handshakes.
- Arbitration is round-robin with a bounded hold (burst) limit.
- The block drives the mux select, registers the selected beat into a one-entry output register, and presents it downstream with valid/ready.
- It sits between the two operand sources of the nibble processor and the shared consumer.

---
 rtl/mux_arb_pkg.sv | 29 ++
 rtl/mux_2to1.sv | 13 +
 rtl/mux_2to1_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_2to1_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arb_pkg;

    localparam int DATA_W = 8;
    localparam int HOLD_W = 4;

    // Registered grant state; 2'b11 is unused and treated as IDLE.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'b00,
        GNT_IN1  = 2'b01,
        GNT_IN2  = 2'b10
    } gnt_e;

    // Requester identity, also the encoding of out_src and last.
    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

    // Burst counter increment that saturates at the hold limit.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt,
                                                   input logic [HOLD_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + 4'd1;
    endfunction

    // Grant state that serves a given requester.
    function automatic gnt_e src2gnt(input logic src);
        return (src == SRC_IN2) ? GNT_IN2 : GNT_IN1;
    endfunction

endpackage

// File: rtl/mux_2to1.sv
// Plain 2:1 data multiplexer: sel=0 passes in1, sel=1 passes in2.
module mux_2to1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// File: rtl/mux_2to1_arbiter.sv
// Round-robin arbiter with a burst-hold limit sharing one mux_2to1 between
// two valid/ready requesters; the selected beat lands in a one-entry output
// register presented downstream with valid/ready.
module mux_2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic [DATA_W-1:0] in2_data,
    output logic              in2_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              sel
);

    localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

    gnt_e              grant, grant_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_adv, hold_nxt;
    logic              last, last_nxt;
    logic [DATA_W-1:0] mux_out;
    logic              can_accept;
    logic              xfer;
    logic              cur_vld, oth_vld, cur_src;

    // The output register can take a beat when empty or draining this cycle.
    assign can_accept = !out_valid || out_ready;

    // Readies depend only on registered grant and out_ready, never on valids.
    assign in1_ready = (grant == GNT_IN1) && can_accept;
    assign in2_ready = (grant == GNT_IN2) && can_accept;
    assign sel       = (grant == GNT_IN2);

    assign xfer = (in1_valid && in1_ready) || (in2_valid && in2_ready);

    mux_2to1 #(.W(DATA_W)) u_mux (
        .in1 (in1_data),
        .in2 (in2_data),
        .sel (sel),
        .out (mux_out)
    );

    // Map the two requesters onto "current holder" and "other" views.
    always_comb begin
        cur_vld = 1'b0;
        oth_vld = 1'b0;
        cur_src = SRC_IN1;
        case (grant)
            GNT_IN1: begin
                cur_vld = in1_valid;
                oth_vld = in2_valid;
                cur_src = SRC_IN1;
            end
            GNT_IN2: begin
                cur_vld = in2_valid;
                oth_vld = in1_valid;
                cur_src = SRC_IN2;
            end
            default: ;
        endcase
    end

    // Burst count if the grant is kept: advances only on a real transfer.
    assign hold_adv = xfer ? hold_inc(hold_cnt, MAX_H) : hold_cnt;

    // Next grant / last-served decision; the hold test uses the post-beat
    // count so the limiting beat and the switch happen on the same edge.
    always_comb begin
        grant_nxt = grant;
        last_nxt  = last;
        case (grant)
            GNT_IDLE: begin
                if (in1_valid && in2_valid)
                    grant_nxt = (last == SRC_IN1) ? GNT_IN2 : GNT_IN1;
                else if (in1_valid)
                    grant_nxt = GNT_IN1;
                else if (in2_valid)
                    grant_nxt = GNT_IN2;
            end
            GNT_IN1, GNT_IN2: begin
                if (oth_vld && (!cur_vld || hold_adv == MAX_H)) begin
                    grant_nxt = src2gnt(!cur_src);
                    last_nxt  = cur_src;
                end else if (!cur_vld) begin
                    grant_nxt = GNT_IDLE;
                    last_nxt  = cur_src;
                end
            end
            default: grant_nxt = GNT_IDLE;
        endcase
    end

    // Any grant change restarts the burst count.
    assign hold_nxt = (grant_nxt != grant) ? '0 : hold_adv;

    // Arbitration state; last starts at in2 so in1 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant    <= GNT_IDLE;
            hold_cnt <= '0;
            last     <= SRC_IN2;
        end else begin
            grant    <= grant_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
        end
    end

    // One-entry output register; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_IN1;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= (grant == GNT_IN2) ? SRC_IN2 : SRC_IN1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Bench for mux_2to1_arbiter: per-requester expected-beat queues filled at
// issue time, drained by an output monitor; directed scenarios add timing and
// arbitration-order checks, then a randomized phase with backpressure.
module tb_mux_2to1_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in1_valid = 1'b0, in2_valid = 1'b0;
    logic [7:0] in1_data = 8'h00, in2_data = 8'h00;
    logic       in1_ready, in2_ready;
    logic       out_valid, out_src, out_ready = 1'b1, sel;
    logic [7:0] out_data;

    mux_2to1_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .in2_valid (in2_valid),
        .in2_data  (in2_data),
        .in2_ready (in2_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] pend1[$], pend2[$];   // beats each requester still has to offer
    logic [7:0] q1[$], q2[$];         // beats expected at the output, per source
    logic       srclog[$];            // source of every beat taken downstream
    int         outcyc[$];            // cycle of every beat taken downstream
    logic       acc1 = 1'b0, acc2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records requester handshakes and checks every output beat.
    always @(negedge clk) begin
        acc1 = in1_valid && in1_ready;
        acc2 = in2_valid && in2_ready;
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            srclog.push_back(out_src);
            outcyc.push_back(cyc);
            if (out_src === 1'b0) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_in1: got beat %0h, expected none", out_data);
                end else chk("sb_in1", out_data, q1.pop_front());
            end else begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_in2: got beat %0h, expected none", out_data);
                end else chk("sb_in2", out_data, q2.pop_front());
            end
        end
    end

    task automatic issue1(input logic [7:0] d);
        pend1.push_back(d);
        q1.push_back(d);
    endtask

    task automatic issue2(input logic [7:0] d);
        pend2.push_back(d);
        q2.push_back(d);
    endtask

    // Advance one cycle; retire accepted beats and present the next ones.
    task automatic tick();
        @(posedge clk); #1;
        if (acc1 === 1'b1 && pend1.size() > 0) void'(pend1.pop_front());
        if (acc2 === 1'b1 && pend2.size() > 0) void'(pend2.pop_front());
        in1_valid = (pend1.size() > 0);
        in1_data  = in1_valid ? pend1[0] : 8'h00;
        in2_valid = (pend2.size() > 0);
        in2_data  = in2_valid ? pend2[0] : 8'h00;
    endtask

    task automatic flush();
        pend1.delete(); pend2.delete(); q1.delete(); q2.delete();
        in1_valid = 1'b0; in2_valid = 1'b0;
        in1_data = 8'h00; in2_data = 8'h00;
    endtask

    task automatic apply_reset(input bit do_chk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        out_ready = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (do_chk) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 8'h00);
            chk("rst_out_src", out_src, 0);
            chk("rst_in1_ready", in1_ready, 0);
            chk("rst_in2_ready", in2_ready, 0);
            chk("rst_sel", sel, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Run with out_ready high until every issued beat has come out (bounded).
    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((pend1.size() + pend2.size() + q1.size() + q2.size() != 0 ||
                out_valid !== 1'b0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", (n < 100), 1);
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp5[9];

        // Reset values, then a lone in1 beat with its exact latency.
        apply_reset(1);
        srclog.delete(); outcyc.delete();
        issue1(8'h3C);
        tick();
        @(negedge clk); chk("t1_rdy_c1", in1_ready, 0);
        tick();
        @(negedge clk); chk("t1_rdy_c2", in1_ready, 1); chk("t1_sel_c2", sel, 0);
        tick();
        @(negedge clk);
        chk("t1_ov_c3", out_valid, 1);
        chk("t1_od_c3", out_data, 8'h3C);
        chk("t1_os_c3", out_src, 0);
        drain();

        // Back in IDLE with in1 served last: a tie now goes to in2.
        srclog.delete();
        issue1(8'h11); issue2(8'h22);
        drain();
        chk("t2_count", srclog.size(), 2);
        if (srclog.size() == 2) begin
            chk("t2_first", srclog[0], 1);
            chk("t2_second", srclog[1], 0);
        end

        // Continuous contention from reset: bursts of MH, no bubbles.
        apply_reset(0);
        srclog.delete(); outcyc.delete();
        for (int i = 0; i < 12; i++) begin
            issue1(8'h40 + 8'(i));
            issue2(8'h80 + 8'(i));
        end
        drain();
        chk("t3_count", srclog.size(), 24);
        if (srclog.size() == 24) begin
            for (int i = 0; i < 24; i++) begin
                chk("t3_src", srclog[i], (i / MH) % 2);
                chk("t3_gap", outcyc[i] - outcyc[0], i);
            end
        end

        // Backpressure holds the registered beat and both readies low.
        srclog.delete();
        out_ready = 1'b0;
        issue1(8'hA5); issue1(8'h5A);
        tick(); tick(); tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_bp_valid", out_valid, 1);
            chk("t4_bp_data", out_data, 8'hA5);
            chk("t4_bp_rdy1", in1_ready, 0);
            chk("t4_bp_rdy2", in2_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("t4_rel_rdy1", in1_ready, 1);
        tick();
        @(negedge clk);
        chk("t4_next_valid", out_valid, 1);
        chk("t4_next_data", out_data, 8'h5A);
        drain();

        // Sole in2 burst past the hold limit; in1 arrives with beat 7.
        srclog.delete(); outcyc.delete();
        for (int i = 1; i <= 8; i++) issue2(8'(i));
        repeat (7) tick();
        issue1(8'h77);
        tick();
        @(negedge clk); chk("t5_sel_keep", sel, 1);
        tick();
        @(negedge clk);
        chk("t5_sel_switch", sel, 0);
        chk("t5_rdy1", in1_ready, 1);
        chk("t5_rdy2", in2_ready, 0);
        drain();
        exp5 = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        chk("t5_count", srclog.size(), 9);
        if (srclog.size() == 9) begin
            for (int i = 0; i < 9; i++) chk("t5_src", srclog[i], exp5[i]);
            for (int i = 0; i < 8; i++) chk("t5_gap", outcyc[i] - outcyc[0], i);
        end

        // Reset in the middle of an in1 burst, then a tie favours in1.
        apply_reset(0);
        for (int i = 0; i < 6; i++) issue1(8'hC0 + 8'(i));
        repeat (4) tick();
        chk("t6_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        flush();
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_sel", sel, 0);
        chk("t6_rdy1", in1_ready, 0);
        chk("t6_rdy2", in2_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        srclog.delete();
        issue1(8'hD1); issue2(8'hD2);
        drain();
        chk("t6_count", srclog.size(), 2);
        if (srclog.size() == 2) chk("t6_first", srclog[0], 0);

        // Random traffic and backpressure; ordering checked per source.
        for (int c = 0; c < 700; c++) begin
            tick();
            if (pend1.size() < 2 && $urandom_range(0, 99) < (c < 450 ? 50 : 85))
                issue1(8'($urandom_range(0, 255)));
            if (pend2.size() < 2 && $urandom_range(0, 99) < (c < 450 ? 50 : 20))
                issue2(8'($urandom_range(0, 255)));
            out_ready = ($urandom_range(0, 99) < 70);
        end
        drain();
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
